rr_arb_wq: RTL and testbench
============================

RR_ARB_WQ -- requirements
Module: rr_arb_wq

Interface
REQ-001 SHALL have parameter N, default 4, number of masters (N >= 2).
REQ-002 SHALL have parameter CW, default 2, quantum/counter width in bits (CW >= 1).
REQ-003 SHALL have derived parameter IW, default $clog2(N), grant index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  N  request per master, bit i = master i.
REQ-007 SHALL have port lock  input  1  current owner requests extension beyond its quantum.
REQ-008 SHALL have port quanta  input  N*CW  field i (bits i*CW +: CW) = q_i; slice for master i = q_i+1 cycles.
REQ-009 SHALL have port gnt  output  N  registered one-hot grant, all-zero when idle.
REQ-010 SHALL have port gnt_id  output  IW  registered index of the granted master, 0 when idle.
REQ-011 SHALL have port gnt_vld  output  1  registered, high iff gnt != 0.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and GRANT (owner o, counter cnt of CW bits).
REQ-013 SHALL keep a rotation pointer ptr (IW bits) = index searched first at the next arbitration.
REQ-014 SHALL search circularly ptr, ptr+1, ... ptr+N-1 mod N and pick the first set req bit.
REQ-015 In IDLE SHALL arbitrate every cycle; on a hit, enter GRANT with o = winner and cnt = 0 at the next edge.
REQ-016 In GRANT SHALL increment cnt each cycle while the hold condition is true, saturating at all-ones.
REQ-017 In GRANT SHALL release when req[o]==0, or when cnt >= q_o and lock==0; the release is evaluated on current-cycle values.
REQ-018 On release SHALL set ptr = o+1 mod N and arbitrate in the same cycle; the new owner is visible on gnt at the next edge.
REQ-019 SHALL include the releasing owner last in the search, so a sole remaining requester is re-granted with cnt = 0 and gnt is held with no gap.
REQ-020 SHALL go to IDLE with gnt = 0 at the next edge when a release finds no requester.
REQ-021 SHALL ignore quantum expiry while lock==1 and req[o]==1; the grant is held indefinitely, with cnt saturated.
REQ-022 SHALL compare q_o live each cycle; if q_o is lowered below cnt mid-grant, release at that cycle's evaluation.
REQ-023 SHALL ensure a request change reaches gnt/gnt_id/gnt_vld after exactly 1 clock; outputs are never combinational from inputs.
REQ-024 SHALL keep gnt strictly one-hot or zero and gnt_id consistent with gnt in every cycle.
REQ-025 SHALL ignore req bits of non-owners during GRANT until a release occurs (no preemption).

Reset
REQ-026 While rst==0 at posedge clk, SHALL set state = IDLE, ptr = 0, cnt = 0, gnt = 0, gnt_id = 0, gnt_vld = 0.
REQ-027 SHALL give reset priority over all other state updates, including mid-grant; outputs return to zero at the first edge with rst==0.
REQ-028 SHALL make the first arbitration after reset use ptr = 0, so master 0 has top priority.

Verification (N=4, CW=2)
REQ-029 Bench SHALL cover: rst=0 for 2 cycles with req=4'b1111 -> gnt=0, gnt_id=0, gnt_vld=0 throughout; after release, gnt=4'b0001 one cycle later.
REQ-030 Bench SHALL cover: req=4'b1111, all q=0 -> gnt 0001,0010,0100,1000,0001,... with each grant lasting 1 cycle.
REQ-031 Bench SHALL cover: req=4'b0101, q0=3, q2=1 -> gnt 0001 for 4 cycles, 0100 for 2 cycles, 0001 for 4 cycles, repeating.
REQ-032 Bench SHALL cover: owner 1 with q1=3 and req=4'b1010, req[1] dropped in its 2nd grant cycle -> gnt=1000 on the next cycle; with req=4'b0010 only -> gnt=0, gnt_vld=0 on the next cycle.
REQ-033 Bench SHALL cover: req=4'b0011, q0=0, lock=1 during master 0 grant -> gnt=0001 held for 6 cycles; lock dropped -> gnt=0010 on the next cycle.
REQ-034 Bench SHALL cover: sole req=4'b0100, q2=1 -> gnt=0100 continuous with gnt_vld never low; rst pulsed low mid-grant -> gnt=0 at that edge, then 0100 again one cycle after rst returns high.

Source files
------------

// File: rtl/rr_arb_wq.sv
// Round-robin arbiter with per-master quanta and owner lock.
//
// Parameters:
//   N  - number of masters (N >= 2)
//   CW - quantum/counter width in bits (CW >= 1)
//   IW - grant index width, $clog2(N)
//
// Ports:
//   clk     - sole clock, all state changes on its rising edge
//   rst     - synchronous active-low reset
//   req     - request per master, bit i = master i
//   lock    - current owner asks to hold the grant beyond its quantum
//   quanta  - field i (bits i*CW +: CW) = q_i; master i's slice lasts q_i+1 cycles
//   gnt     - registered one-hot grant, zero when idle
//   gnt_id  - registered index of the granted master, zero when idle
//   gnt_vld - registered, high whenever gnt is non-zero
module rr_arb_wq #(
  parameter int N  = 4,
  parameter int CW = 2,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            lock,
  input  logic [N*CW-1:0] quanta,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_vld
);

  localparam int unsigned NU = N;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   q_own;
  logic [IW-1:0]   nxt_own;
  logic [IW-1:0]   base;
  logic [IW-1:0]   win;
  logic            hit;
  logic            rel;
  logic [N-1:0]    gnt_d;

  // Live quantum of the current owner.
  always_comb begin
    q_own = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (own_q == IW'(i)) q_own = quanta[i*CW +: CW];
    end
  end

  assign nxt_own = (own_q == IW'(N-1)) ? '0 : own_q + IW'(1);

  assign rel = (state_q == GRANT) &&
               (!req[own_q] || ((cnt_q >= q_own) && !lock));

  // On release the search starts just past the owner, which puts the
  // releasing owner last; in IDLE it starts at the rotation pointer.
  assign base = (state_q == GRANT) ? nxt_own : ptr_q;

  always_comb begin
    int unsigned idx;
    logic [IW-1:0] idx_t;
    hit = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      idx   = base;
      idx   = (idx + i) % NU;
      idx_t = IW'(idx);
      if (!hit && req[idx_t]) begin
        hit = 1'b1;
        win = idx_t;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = GRANT;
          own_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = nxt_own;
          cnt_d = '0;
          if (hit) begin
            own_d = win;
          end else begin
            state_d = IDLE;
            own_d   = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) gnt_d[own_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      gnt_id  <= (state_d == GRANT) ? own_d : '0;
      gnt_vld <= (state_d == GRANT);
    end
  end

endmodule

// File: tb/tb_rr_arb_wq.sv
module tb_rr_arb_wq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       lock;
  logic [7:0] quanta;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  int total = 0;
  int bad   = 0;

  rr_arb_wq #(.N(4), .CW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .quanta(quanta),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic [7:0] quanta;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic lk,
                      input logic [7:0] qn, input logic [3:0] eg,
                      input string name);
    @(negedge clk);
    rst = r; req = rq; lock = lk; quanta = qn;
    @(posedge clk);
    #1;
    total++;
    if (gnt !== eg) begin
      bad++;
      $display("FAIL %s gnt: got %b want %b", name, gnt, eg);
    end
    total++;
    if (gnt_id !== id_of(eg)) begin
      bad++;
      $display("FAIL %s gnt_id: got %0d want %0d", name, gnt_id, id_of(eg));
    end
    total++;
    if (gnt_vld !== (eg != 4'b0)) begin
      bad++;
      $display("FAIL %s gnt_vld: got %b want %b", name, gnt_vld, (eg != 4'b0));
    end
  endtask

  task automatic do_reset(input logic [3:0] rq);
    step(1'b0, rq, 1'b0, 8'h00, 4'b0000, "reset");
    step(1'b0, rq, 1'b0, 8'h00, 4'b0000, "reset");
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rq,
                              input logic lk, input logic [7:0] qn,
                              input logic [3:0] eg);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.quanta = qn; v.exp_gnt = eg;
    return v;
  endfunction

  initial begin
    rst = 1'b0; req = 4'b0; lock = 1'b0; quanta = 8'h00;

    // Reset held with all requesting, then master 0 first.
    tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h00, 4'b0001));
    // All quanta zero: one cycle each, rotating.
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h00, 4'b0010));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h00, 4'b1000));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h00, 4'b0001));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 8'h00, 4'b0010));
    // req=0101, q0=3, q2=1; owner 1 drops out and master 2 takes over.
    tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 8'h13, 4'b0100));
    tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 8'h13, 4'b0100));
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 8'h13, 4'b0001));
      for (int j = 0; j < 2; j++)
        tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 8'h13, 4'b0100));
    end

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].quanta,
           tbl[i].exp_gnt, $sformatf("vec%0d", i));

    // Owner 1 (q1=3) drops its request in its second cycle.
    do_reset(4'b0000);
    step(1'b1, 4'b1010, 1'b0, 8'h0C, 4'b0010, "drop_a");
    step(1'b1, 4'b1010, 1'b0, 8'h0C, 4'b0010, "drop_b");
    step(1'b1, 4'b1000, 1'b0, 8'h0C, 4'b1000, "drop_c");

    // Sole requester 1 drops: goes idle.
    do_reset(4'b0000);
    step(1'b1, 4'b0010, 1'b0, 8'h0C, 4'b0010, "idle_a");
    step(1'b1, 4'b0010, 1'b0, 8'h0C, 4'b0010, "idle_b");
    step(1'b1, 4'b0000, 1'b0, 8'h0C, 4'b0000, "idle_c");

    // Lock holds master 0 past its zero quantum.
    do_reset(4'b0000);
    for (int j = 0; j < 6; j++)
      step(1'b1, 4'b0011, 1'b1, 8'h00, 4'b0001, $sformatf("lock%0d", j));
    step(1'b1, 4'b0011, 1'b0, 8'h00, 4'b0010, "unlock");

    // Quantum lowered below the running count releases immediately.
    do_reset(4'b0000);
    step(1'b1, 4'b0011, 1'b0, 8'h03, 4'b0001, "qlow_a");
    step(1'b1, 4'b0011, 1'b0, 8'h03, 4'b0001, "qlow_b");
    step(1'b1, 4'b0011, 1'b0, 8'h03, 4'b0001, "qlow_c");
    step(1'b1, 4'b0011, 1'b0, 8'h01, 4'b0010, "qlow_d");

    // Sole requester 2 is re-granted with no gap; reset mid-grant.
    do_reset(4'b0000);
    for (int j = 0; j < 6; j++)
      step(1'b1, 4'b0100, 1'b0, 8'h10, 4'b0100, $sformatf("sole%0d", j));
    step(1'b0, 4'b0100, 1'b0, 8'h10, 4'b0000, "midrst");
    step(1'b1, 4'b0100, 1'b0, 8'h10, 4'b0100, "post_rst_a");
    step(1'b1, 4'b0100, 1'b0, 8'h10, 4'b0100, "post_rst_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
